// File: rtl/booth_sequencer_if.sv
// Operand/result handshake bundle for booth_sequencer.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
//
// Signals:
//   in_valid, multiplicand, multiplier : operand pair offered by the source
//   in_ready                           : sequencer can take a pair (IDLE)
//   out_valid, product                 : signed product offered to the consumer
//   out_ready                          : consumer takes the product
//   busy                               : an operation is running or waiting
// Modports:
//   master : source/consumer side (drives operands and out_ready)
//   slave  : the sequencer
interface booth_sequencer_if #(
  parameter int WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid,
    output multiplicand,
    output multiplier,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  multiplicand,
    input  multiplier,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );
endinterface

// File: rtl/booth_sequencer.sv
// Iterative radix-2 Booth multiplier, one Booth step per clock.
// Latency: WIDTH cycles from the accept edge to out_valid; WIDTH+2 cycles per product.
// Backpressure: product held in DONE until out_ready; no new pair until after the handshake.
//
// Ports:
//   clk   : single clock, all state on the rising edge
//   reset : synchronous active-high reset, overrides everything
//   bus   : slave side of booth_sequencer_if (operands in, product out)
module booth_sequencer #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  booth_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [CNT_WIDTH-1:0]   r_count;
  logic [WIDTH:0]         r_a;        // one bit wider than M so -2^(WIDTH-1) cannot overflow
  logic [WIDTH-1:0]       r_q;
  logic                   r_q_m1;
  logic [WIDTH-1:0]       r_m;
  logic [2*WIDTH-1:0]     r_product;

  logic                   w_accept;
  logic                   w_handshake;
  logic                   w_last;
  logic [WIDTH:0]         w_m_ext;
  logic [WIDTH:0]         w_a_sum;
  logic [WIDTH:0]         w_a_shift;
  logic [WIDTH-1:0]       w_q_shift;
  logic                   w_q_m1_shift;
  logic [2*WIDTH-1:0]     w_product_step;

  // Handshake qualifiers come from registered state only.
  assign w_accept    = bus.in_valid  && (r_state == S_IDLE);
  assign w_handshake = bus.out_ready && (r_state == S_DONE);
  assign w_last      = (r_count == CNT_WIDTH'(WIDTH - 1));

  // ------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_handshake) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // One Booth step: add/subtract M depending on {Q[0], Q_-1}, then
  // arithmetic right shift of {A, Q, Q_-1} by one.
  // ------------------------------------------------------------------
  always_comb begin
    w_m_ext = {r_m[WIDTH-1], r_m};
    w_a_sum = r_a;
    case ({r_q[0], r_q_m1})
      2'b01:   w_a_sum = r_a + w_m_ext;
      2'b10:   w_a_sum = r_a - w_m_ext;
      default: w_a_sum = r_a;
    endcase
    w_a_shift      = {w_a_sum[WIDTH], w_a_sum[WIDTH:1]};
    w_q_shift      = {w_a_sum[0], r_q[WIDTH-1:1]};
    w_q_m1_shift   = r_q[0];
    // After the final shift the exact product is the low 2*WIDTH bits of {A,Q};
    // the extra A bit is only a sign copy by then.
    w_product_step = {w_a_shift[WIDTH-1:0], w_q_shift};
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_q_m1    <= 1'b0;
      r_m       <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Operands are sampled only here; later input changes are ignored.
          if (w_accept) begin
            r_m     <= bus.multiplicand;
            r_q     <= bus.multiplier;
            r_a     <= '0;
            r_q_m1  <= 1'b0;
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_a    <= w_a_shift;
          r_q    <= w_q_shift;
          r_q_m1 <= w_q_m1_shift;
          // The counter stops at WIDTH-1 rather than wrapping; the next
          // accept reloads it.
          if (w_last) begin
            r_product <= w_product_step;
          end else begin
            r_count <= r_count + CNT_WIDTH'(1);
          end
        end
        default: begin
          // DONE: everything held so the product stays stable under backpressure.
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ------------------------------------------------------------------
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.product   = r_product;

endmodule
